// File: rtl/spi_register_bridge_pkg.sv
// spi_register_bridge_pkg: FSM state encoding and small helpers shared by the bridge files.
`default_nettype none

package spi_register_bridge_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      RESP = 2'd2
   } state_e;

   localparam logic [7:0] ERR_MAX = 8'hFF;

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == ERR_MAX) ? v : v + 8'd1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/spi_register_bridge_wait_timeout_counter.sv
// wait_timeout_counter: counts enabled cycles and flags the cycle on which the TIMEOUT-th wait ends.
`default_nettype none

module wait_timeout_counter #(
   parameter int TIMEOUT = 255
) (
   input  logic clk,
   input  logic nreset,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int             CW   = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0]  LAST = CW'(TIMEOUT - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = '0;
      end else if (enable && (cnt_q != LAST)) begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!nreset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // Count holds the number of already-completed wait cycles, so LAST marks the final one.
   assign expired = enable && (cnt_q == LAST);

endmodule

`default_nettype wire

// File: rtl/spi_register_bridge.sv
// spi_register_bridge: turns each received SPI word into one register bus access and
// stages the outcome as the word shifted out in the next chip-select frame.
`default_nettype none

module spi_register_bridge
   import spi_register_bridge_pkg::*;
#(
   parameter int WIDTH      = 32,
   parameter int ADDR_WIDTH = 7,
   parameter int DATA_WIDTH = 24,
   parameter int TIMEOUT    = 255
) (
   input  logic                  system_clk,
   input  logic                  system_nreset,
   input  logic                  cs_start,
   input  logic                  cs_stop,
   input  logic                  value_valid,
   input  logic [WIDTH-1:0]      value_mosi,
   output logic [WIDTH-1:0]      value_miso,
   output logic                  bus_req,
   output logic                  bus_we,
   output logic [ADDR_WIDTH-1:0] bus_addr,
   output logic [DATA_WIDTH-1:0] bus_wdata,
   input  logic                  bus_ack,
   input  logic [DATA_WIDTH-1:0] bus_rdata,
   output logic [7:0]            err_count
);

   localparam logic [WIDTH-1:0] RESP_NONE    = '0;
   localparam logic [WIDTH-1:0] RESP_BUSY    = {1'b0, {ADDR_WIDTH{1'b1}}, {DATA_WIDTH{1'b0}}};
   localparam logic [WIDTH-1:0] RESP_INVALID = {1'b0, {ADDR_WIDTH{1'b1}}, {DATA_WIDTH{1'b1}}};

   state_e                state_q, state_d;
   logic                  req_q, req_d;
   logic                  we_q, we_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic [WIDTH-1:0]      miso_q, miso_d;
   logic [7:0]            err_q, err_d;
   logic                  err_inc;
   logic                  expired;
   logic                  unused_cs_start;

   // Frame start needs no action: the slave copies value_miso by itself.
   assign unused_cs_start = cs_start;

   wait_timeout_counter #(
      .TIMEOUT (TIMEOUT)
   ) u_wait (
      .clk     (system_clk),
      .nreset  (system_nreset),
      .clear   (state_q != REQ),
      .enable  (state_q == REQ),
      .expired (expired)
   );

   always_comb begin
      state_d = state_q;
      req_d   = req_q;
      we_d    = we_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      miso_d  = miso_q;
      err_inc = 1'b0;
      case (state_q)
         IDLE: begin
            if (cs_stop && value_valid) begin
               we_d    = value_mosi[WIDTH-1];
               addr_d  = value_mosi[WIDTH-2 -: ADDR_WIDTH];
               wdata_d = value_mosi[DATA_WIDTH-1:0];
               miso_d  = RESP_BUSY;
               req_d   = 1'b1;
               state_d = REQ;
            end else if (cs_stop) begin
               miso_d  = RESP_INVALID;
               err_inc = 1'b1;
            end
         end
         REQ: begin
            err_inc = cs_stop;
            // Ack takes priority over a timeout expiring on the same edge.
            if (bus_ack) begin
               if (!we_q) begin
                  rdata_d = bus_rdata;
               end
               req_d   = 1'b0;
               state_d = RESP;
            end else if (expired) begin
               req_d   = 1'b0;
               miso_d  = {1'b0, addr_q, {DATA_WIDTH{1'b0}}};
               state_d = IDLE;
            end
         end
         RESP: begin
            err_inc = cs_stop;
            miso_d  = {1'b1, addr_q, (we_q ? wdata_q : rdata_q)};
            state_d = IDLE;
         end
         default: begin
            req_d   = 1'b0;
            state_d = IDLE;
         end
      endcase
      err_d = err_inc ? sat_inc8(err_q) : err_q;
   end

   always_ff @(posedge system_clk) begin
      if (!system_nreset) begin
         state_q <= IDLE;
         req_q   <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         miso_q  <= RESP_NONE;
         err_q   <= 8'd0;
      end else begin
         state_q <= state_d;
         req_q   <= req_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         miso_q  <= miso_d;
         err_q   <= err_d;
      end
   end

   assign value_miso = miso_q;
   assign bus_req    = req_q;
   assign bus_we     = we_q;
   assign bus_addr   = addr_q;
   assign bus_wdata  = wdata_q;
   assign err_count  = err_q;

endmodule

`default_nettype wire

// File: tb/tb_spi_register_bridge.sv
// tb_spi_register_bridge: directed scenarios plus randomized traffic against a transaction-level model.
`default_nettype none

module tb_spi_register_bridge;

   localparam int TO = 15;

   logic        clk = 1'b0;
   logic        nreset = 1'b0;
   logic        cs_start = 1'b0;
   logic        cs_stop = 1'b0;
   logic        value_valid = 1'b0;
   logic [31:0] value_mosi = '0;
   logic [31:0] value_miso;
   logic        bus_req;
   logic        bus_we;
   logic [6:0]  bus_addr;
   logic [23:0] bus_wdata;
   logic        bus_ack = 1'b0;
   logic [23:0] bus_rdata = '0;
   logic [7:0]  err_count;

   int n_cmp = 0;
   int n_bad = 0;

   spi_register_bridge #(
      .WIDTH      (32),
      .ADDR_WIDTH (7),
      .DATA_WIDTH (24),
      .TIMEOUT    (TO)
   ) dut (
      .system_clk    (clk),
      .system_nreset (nreset),
      .cs_start      (cs_start),
      .cs_stop       (cs_stop),
      .value_valid   (value_valid),
      .value_mosi    (value_mosi),
      .value_miso    (value_miso),
      .bus_req       (bus_req),
      .bus_we        (bus_we),
      .bus_addr      (bus_addr),
      .bus_wdata     (bus_wdata),
      .bus_ack       (bus_ack),
      .bus_rdata     (bus_rdata),
      .err_count     (err_count)
   );

   always #5 clk = ~clk;

   // Transaction-level view: one pending access, how long it has waited, and a staged reply.
   typedef struct packed {
      logic        req;
      logic        we;
      logic [6:0]  addr;
      logic [23:0] wdata;
      logic [31:0] miso;
      logic [7:0]  err;
      logic [15:0] waited;
      logic        resp_pend;
      logic [31:0] resp_word;
   } mdl_t;

   mdl_t m = '0;

   function automatic logic [7:0] bump(input logic [7:0] e);
      return (e == 8'd255) ? e : e + 8'd1;
   endfunction

   function automatic mdl_t step(input mdl_t s, input logic rst_n, input logic stop,
                                 input logic valid, input logic [31:0] mosi,
                                 input logic ack, input logic [23:0] rdata);
      mdl_t n;
      n = s;
      if (!rst_n) return '0;
      if (s.resp_pend) begin
         n.miso      = s.resp_word;
         n.resp_pend = 1'b0;
         if (stop) n.err = bump(s.err);
      end else if (s.req) begin
         if (stop) n.err = bump(s.err);
         n.waited = s.waited + 16'd1;
         if (ack) begin
            n.req       = 1'b0;
            n.resp_pend = 1'b1;
            n.resp_word = {1'b1, s.addr, (s.we ? s.wdata : rdata)};
         end else if (n.waited == 16'(TO)) begin
            n.req  = 1'b0;
            n.miso = {1'b0, s.addr, 24'h0};
         end
      end else if (stop) begin
         if (valid) begin
            n.req    = 1'b1;
            n.we     = mosi[31];
            n.addr   = mosi[30:24];
            n.wdata  = mosi[23:0];
            n.waited = 16'd0;
            n.miso   = 32'h7F00_0000;
         end else begin
            n.miso = 32'h7FFF_FFFF;
            n.err  = bump(s.err);
         end
      end
      return n;
   endfunction

   always @(posedge clk) begin
      m <= step(m, nreset, cs_stop, value_valid, value_mosi, bus_ack, bus_rdata);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      chk("cyc_bus_req",   32'(bus_req),   32'(m.req));
      chk("cyc_bus_we",    32'(bus_we),    32'(m.we));
      chk("cyc_bus_addr",  32'(bus_addr),  32'(m.addr));
      chk("cyc_bus_wdata", 32'(bus_wdata), 32'(m.wdata));
      chk("cyc_miso",      value_miso,     m.miso);
      chk("cyc_err",       32'(err_count), 32'(m.err));
   end

   task automatic frame(input logic valid, input logic [31:0] word);
      cs_stop     = 1'b1;
      value_valid = valid;
      value_mosi  = word;
      @(negedge clk);
      cs_stop     = 1'b0;
      value_valid = 1'b0;
   endtask

   task automatic do_reset();
      nreset = 1'b0;
      repeat (2) @(negedge clk);
      nreset = 1'b1;
   endtask

   initial begin
      int n;
      int ack_div;
      repeat (3) @(negedge clk);
      chk("rst_req",  32'(bus_req),   32'h0);
      chk("rst_miso", value_miso,     32'h0);
      chk("rst_err",  32'(err_count), 32'h0);
      nreset = 1'b1;
      @(negedge clk);

      // Write with ack two cycles after the request rises.
      frame(1'b1, 32'h8512_3456);
      chk("wr_req",   32'(bus_req),   32'h1);
      chk("wr_we",    32'(bus_we),    32'h1);
      chk("wr_addr",  32'(bus_addr),  32'h05);
      chk("wr_wdata", 32'(bus_wdata), 32'h12_3456);
      chk("wr_busy",  value_miso,     32'h7F00_0000);
      @(negedge clk);
      bus_ack = 1'b1;
      @(negedge clk);
      bus_ack = 1'b0;
      chk("wr_req_drop", 32'(bus_req), 32'h0);
      chk("wr_busy2",    value_miso,   32'h7F00_0000);
      @(negedge clk);
      chk("wr_resp",     value_miso,   32'h8512_3456);
      chk("wr_resp_mdl", m.miso,       32'h8512_3456);

      // Read acked at the earliest legal edge.
      frame(1'b1, 32'h0500_0000);
      chk("rd_we", 32'(bus_we), 32'h0);
      bus_ack   = 1'b1;
      bus_rdata = 24'hAB_CDEF;
      @(negedge clk);
      bus_ack   = 1'b0;
      bus_rdata = 24'h0;
      @(negedge clk);
      chk("rd_resp", value_miso, 32'h85AB_CDEF);
      cs_start = 1'b1;
      @(negedge clk);
      cs_start = 1'b0;
      chk("rd_hold", value_miso, 32'h85AB_CDEF);

      // Read that never gets an ack.
      frame(1'b1, 32'h0500_0000);
      n = 0;
      while (bus_req && n < 100) begin
         n++;
         @(negedge clk);
      end
      chk("to_cycles", 32'(n), 32'(TO));
      chk("to_resp",   value_miso, 32'h0500_0000);
      chk("to_mdl",    m.miso,     32'h0500_0000);

      // Short frames until the error counter saturates.
      frame(1'b0, 32'h0);
      chk("short_miso", value_miso,     32'h7FFF_FFFF);
      chk("short_err",  32'(err_count), 32'h1);
      for (int i = 0; i < 299; i++) frame(1'b0, $urandom);
      chk("sat_err", 32'(err_count), 32'd255);

      // Second frame arriving while the first access is pending.
      do_reset();
      frame(1'b1, 32'h91AA_AAAA);
      frame(1'b1, 32'h8312_3456);
      bus_ack = 1'b1;
      @(negedge clk);
      bus_ack = 1'b0;
      @(negedge clk);
      chk("dbl_resp", value_miso,     32'h91AA_AAAA);
      chk("dbl_err",  32'(err_count), 32'h1);
      n = 0;
      for (int i = 0; i < 5; i++) begin
         if (bus_req) n++;
         @(negedge clk);
      end
      chk("dbl_noreq", 32'(n), 32'h0);

      // Reset pulse mid-access with a coincident ack.
      frame(1'b1, 32'h8512_3456);
      nreset  = 1'b0;
      bus_ack = 1'b1;
      @(negedge clk);
      nreset  = 1'b1;
      bus_ack = 1'b0;
      chk("rr_req",  32'(bus_req),   32'h0);
      chk("rr_miso", value_miso,     32'h0);
      chk("rr_err",  32'(err_count), 32'h0);
      repeat (3) @(negedge clk);
      chk("rr_noresp", value_miso, 32'h0);

      // Randomized traffic; the per-cycle compare tracks every output.
      for (int c = 0; c < 4000; c++) begin
         ack_div     = (c < 2000) ? 3 : 20;
         cs_stop     = ($urandom_range(0, 5) == 0);
         value_valid = ($urandom_range(0, 3) != 0);
         value_mosi  = $urandom;
         cs_start    = ($urandom_range(0, 7) == 0);
         bus_rdata   = 24'($urandom);
         bus_ack     = m.req ? ($urandom_range(0, ack_div - 1) == 0)
                             : ($urandom_range(0, 9) == 0);
         nreset      = ($urandom_range(0, 299) != 0);
         @(negedge clk);
      end
      cs_stop  = 1'b0;
      bus_ack  = 1'b0;
      cs_start = 1'b0;
      nreset   = 1'b1;
      @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

`default_nettype wire
